serial_tx: RTL

Standalone UART transmitter for the serial link: accepts bytes from the host logic through a strobe interface, buffers them in a small FIFO, and shifts each one out on `tx` as an 8N1 frame at a fixed baud rate. It is the transmit-side counterpart of the receiver path in `serial` and shares its baud arithmetic, so both ends run at an identical bit period from the same system clock.

---
 rtl/serial_tx.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// 8N1 UART transmitter: a small byte FIFO feeds a start/data/stop shifter.
// The bit period is CLK_MUL system clocks, the same as the receive path.
module serial_tx #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD          = 9600,
  parameter int CLK_MUL       = CLK_FREQ / BAUD,
  parameter int CLK_MUL_WIDTH = $clog2(CLK_MUL),
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dat_t,
  input  logic       txe,
  input  logic       ovf_rst,
  output logic       tx,
  output logic       full,
  output logic       busy,
  output logic       ovf
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CLK_MUL_WIDTH-1:0] BIT_LAST = CLK_MUL_WIDTH'(CLK_MUL - 1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                   state;
  logic [7:0]               mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [PW:0]              count, count_next;
  logic [CLK_MUL_WIDTH-1:0] baud_cnt;
  logic [2:0]               bit_idx;
  logic [7:0]               shift;
  logic                     bit_end, push, pop, to_idle, frame_gap;

  // A pop can only happen where the FSM is between frames: IDLE, or the last STOP cycle.
  assign bit_end   = (baud_cnt == BIT_LAST);
  assign frame_gap = (state == IDLE) | ((state == STOP) & bit_end);
  assign push      = txe & ~full;
  assign pop       = frame_gap & (count != '0);
  assign to_idle   = frame_gap & (count == '0);

  always_comb begin
    count_next = count;
    if (push & ~pop)      count_next = count + 1'b1;
    else if (pop & ~push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dat_t;
  end

  // full is gated on its registered value, so a write while full is dropped even on a pop cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      if (txe & full)   ovf <= 1'b1;
      else if (ovf_rst) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      busy     <= 1'b0;
    end else begin
      busy <= ~to_idle | (count_next != '0);
      if (state != IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: if (pop) begin
          shift    <= mem[rd_ptr];
          baud_cnt <= '0;
          state    <= START;
          tx       <= 1'b0;
        end
        START: if (bit_end) begin
          state   <= DATA;
          bit_idx <= '0;
          tx      <= shift[0];
        end
        DATA: if (bit_end) begin
          shift <= shift >> 1;
          if (bit_idx == 3'd7) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            tx      <= shift[1];
          end
        end
        STOP: if (bit_end) begin
          // Chain straight into the next start bit when more bytes are queued.
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            tx    <= 1'b0;
          end else begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
